lsu_data_mem: RTL

- Memory-side responder for the load/store encoding the control unit produces: MemWrite plus the funct3 sub-op (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Accepts one access per request handshake and performs byte/halfword/word reads and writes on an internal byte-enabled synchronous word RAM.
- Sign- or zero-extends load data.
- Splits a misaligned access that crosses a word boundary into two RAM cycles.
- Sits between the core's ALU address/rs2 path and the writeback mux (ResultSrc=01).

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/data_ram.sv | 33 +++
 rtl/lsu_data_mem.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store encodings and FSM state type for the LSU data memory.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // log2 of the access width in bytes
    typedef logic [1:0] size_t;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} lsu_state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port byte-enabled word RAM with a registered read port; contents are not reset.
module data_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // rdata only changes on a read, so it holds across non-access cycles
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lsu_data_mem.sv
// Load/store responder: byte/half/word access on a word RAM, splitting
// word-crossing accesses into two RAM cycles and extending load data.
module lsu_data_mem
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    lsu_state_t         state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [IDX_W+1:0]   addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        lo_q, lo_d;

    logic               ram_en, ram_we;
    logic [3:0]         ram_be;
    logic [IDX_W-1:0]   ram_idx, w0, w1;
    logic [31:0]        ram_wdata, ram_rdata;

    logic [1:0]         off;
    size_t              size;
    logic [7:0]         mask;
    logic               split;
    logic [63:0]        wdata64;
    logic [31:0]        rd_word, lo_word, hi_word;

    // address bits above the RAM are aliased away
    logic unused_addr;
    assign unused_addr = ^req_addr[31:IDX_W+2];

    assign off     = addr_q[1:0];
    assign size    = f3_q[1:0];
    assign w0      = addr_q[IDX_W+1:2];
    assign w1      = w0 + 1'b1;
    assign mask    = (size == 2'b00) ? (8'h01 << off) :
                     (size == 2'b01) ? (8'h03 << off) : (8'h0F << off);
    assign split   = |mask[7:4];
    assign wdata64 = {32'b0, wdata_q} << {off, 3'b000};

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lo_d      = lo_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'b0;
        ram_idx   = w0;
        ram_wdata = 32'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[IDX_W+1:0];
                    wdata_d = req_wdata;
                    state_d = f3_legal(req_we, req_funct3) ? ACC0 : RESP;
                end
            end
            ACC0: begin
                ram_en    = 1'b1;
                ram_we    = we_q;
                ram_be    = mask[3:0];
                ram_wdata = wdata64[31:0];
                state_d   = split ? ACC1 : RESP;
            end
            ACC1: begin
                ram_en    = 1'b1;
                ram_we    = we_q;
                ram_idx   = w1;
                ram_be    = mask[7:4];
                ram_wdata = wdata64[63:32];
                lo_d      = ram_rdata;
                state_d   = RESP;
            end
            default: state_d = IDLE;
        endcase
        // a reset landing on an access edge must not commit that access
        if (rst) begin
            ram_en = 1'b0;
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= '0;
            wdata_q <= 32'b0;
            lo_q    <= 32'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
        end
    end

    data_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // split loads hold the first word in lo_q; otherwise the RAM still shows the ACC0 read
    assign lo_word = split ? lo_q : ram_rdata;
    assign hi_word = split ? ram_rdata : 32'b0;
    assign rd_word = 32'({hi_word, lo_word} >> {off, 3'b000});

    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        rsp_valid = (state_q == RESP);
        rsp_err   = 1'b0;
        rsp_rdata = 32'b0;
        if (state_q == RESP) begin
            rsp_err = !f3_legal(we_q, f3_q);
            if (!rsp_err && !we_q) begin
                case (f3_q)
                    F3_B:    rsp_rdata = {{24{rd_word[7]}}, rd_word[7:0]};
                    F3_BU:   rsp_rdata = {24'b0, rd_word[7:0]};
                    F3_H:    rsp_rdata = {{16{rd_word[15]}}, rd_word[15:0]};
                    F3_HU:   rsp_rdata = {16'b0, rd_word[15:0]};
                    default: rsp_rdata = rd_word;
                endcase
            end
        end
    end

endmodule
